// File: rtl/mixer_pkg.sv
// rtl/mixer_pkg.sv - shared widths, colour type and constants for the sprite layer mixer
package mixer_pkg;

  localparam int RGB_W       = 3;
  localparam int FLASH_CNT_W = 8;

  typedef logic [RGB_W-1:0] rgb_t;

  localparam rgb_t BLACK = 3'b000;
  localparam rgb_t WHITE = 3'b111;

endpackage

// File: rtl/mixer_flash_timer.sv
// rtl/mixer_flash_timer.sv - per-layer hit-flash frame counter (load on trigger, count down on frame tick)
module mixer_flash_timer
  import mixer_pkg::*;
#(
  parameter int FLASH_FRAMES = 8
) (
  input  logic clk25,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic active,
  output logic phase
);

  localparam logic [FLASH_CNT_W-1:0] LOAD_VAL = FLASH_CNT_W'(FLASH_FRAMES);

  logic [FLASH_CNT_W-1:0] cnt;

  // A trigger always wins over a coincident frame tick so the flash restarts at full length.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - FLASH_CNT_W'(1);
    end
  end

  assign active = (cnt != '0);
  assign phase  = cnt[0];

endmodule

// File: rtl/sprite_layer_mixer.sv
// rtl/sprite_layer_mixer.sv - two-stage priority mixer of sprite layers with hit-flash and delay-matched syncs
// Optional background colour input bg_rgb when MIXER_BG_EN is defined.
module sprite_layer_mixer
  import mixer_pkg::*;
#(
  parameter int LAYERS       = 6,
  parameter int OUT_W        = 4,
  parameter int FLASH_FRAMES = 8,
  parameter int SYNC_POL     = 0
) (
  input  logic                      clk25,
  input  logic                      rst_n,
  input  logic [RGB_W*LAYERS-1:0]   layer_rgb_flat,
  input  logic [LAYERS-1:0]         layer_valid,
  input  logic [LAYERS-1:0]         layer_enable,
  input  logic [LAYERS-1:0]         flash_trigger,
  input  logic                      video_on,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
`ifdef MIXER_BG_EN
  input  logic [RGB_W-1:0]          bg_rgb,
`endif
  output logic [OUT_W-1:0]          vga_r,
  output logic [OUT_W-1:0]          vga_g,
  output logic [OUT_W-1:0]          vga_b,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic [LAYERS-1:0]         flash_active
);

  localparam logic SYNC_ACT = (SYNC_POL != 0);

  logic [LAYERS-1:0]       phase;
  logic [LAYERS-1:0]       eff_valid;
  logic                    frame_tick;

  logic [RGB_W*LAYERS-1:0] rgb_s1;
  logic [LAYERS-1:0]       eff_s1;
  logic [LAYERS-1:0]       white_s1;
  logic                    video_s1;
  logic                    hs_s1;
  logic                    vs_s1;
  logic                    vs_prev;
`ifdef MIXER_BG_EN
  rgb_t                    bg_s1;
`endif

  rgb_t                    pix_c;
  rgb_t                    pix_s2;

  // During the dark half of a blink the layer is transparent, letting lower layers show through.
  assign eff_valid  = layer_valid & layer_enable & ~(flash_active & ~phase);
  assign frame_tick = (vs_s1 == SYNC_ACT) && (vs_prev != SYNC_ACT);

  for (genvar i = 0; i < LAYERS; i++) begin : g_flash
    mixer_flash_timer #(
      .FLASH_FRAMES (FLASH_FRAMES)
    ) u_flash_timer (
      .clk25  (clk25),
      .rst_n  (rst_n),
      .load   (flash_trigger[i]),
      .tick   (frame_tick),
      .active (flash_active[i]),
      .phase  (phase[i])
    );
  end

  // Sync registers reset to the inactive level so no false frame tick or sync pulse appears after reset.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      rgb_s1   <= '0;
      eff_s1   <= '0;
      white_s1 <= '0;
      video_s1 <= 1'b0;
      hs_s1    <= ~SYNC_ACT;
      vs_s1    <= ~SYNC_ACT;
      vs_prev  <= ~SYNC_ACT;
`ifdef MIXER_BG_EN
      bg_s1    <= BLACK;
`endif
    end else begin
      rgb_s1   <= layer_rgb_flat;
      eff_s1   <= eff_valid;
      white_s1 <= flash_active & phase;
      video_s1 <= video_on;
      hs_s1    <= hsync_in;
      vs_s1    <= vsync_in;
      vs_prev  <= vs_s1;
`ifdef MIXER_BG_EN
      bg_s1    <= bg_rgb;
`endif
    end
  end

  always_comb begin
    logic found;
    found = 1'b0;
`ifdef MIXER_BG_EN
    pix_c = bg_s1;
`else
    pix_c = BLACK;
`endif
    for (int i = 0; i < LAYERS; i++) begin
      if (!found && eff_s1[i]) begin
        found = 1'b1;
        pix_c = white_s1[i] ? WHITE : rgb_s1[RGB_W*i +: RGB_W];
      end
    end
    if (!video_s1) begin
      pix_c = BLACK;
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      pix_s2    <= BLACK;
      hsync_out <= ~SYNC_ACT;
      vsync_out <= ~SYNC_ACT;
    end else begin
      pix_s2    <= pix_c;
      hsync_out <= hs_s1;
      vsync_out <= vs_s1;
    end
  end

  assign vga_r = {OUT_W{pix_s2[2]}};
  assign vga_g = {OUT_W{pix_s2[1]}};
  assign vga_b = {OUT_W{pix_s2[0]}};

endmodule

// File: tb/tb_sprite_layer_mixer.sv
// tb/tb_sprite_layer_mixer.sv - randomized and directed bench for sprite_layer_mixer against a frame-level model
module tb_sprite_layer_mixer;

  localparam int   L   = 6;
  localparam int   OW  = 4;
  localparam int   FF  = 8;
  localparam logic ACT = 1'b0;

  logic            clk25 = 1'b0;
  logic            rst_n;
  logic [3*L-1:0]  layer_rgb_flat;
  logic [L-1:0]    layer_valid;
  logic [L-1:0]    layer_enable;
  logic [L-1:0]    flash_trigger;
  logic            video_on;
  logic            hsync_in;
  logic            vsync_in;
`ifdef MIXER_BG_EN
  logic [2:0]      bg_rgb;
`endif
  logic [OW-1:0]   vga_r;
  logic [OW-1:0]   vga_g;
  logic [OW-1:0]   vga_b;
  logic            hsync_out;
  logic            vsync_out;
  logic [L-1:0]    flash_active;

  always #20 clk25 = ~clk25;

  sprite_layer_mixer #(
    .LAYERS       (L),
    .OUT_W        (OW),
    .FLASH_FRAMES (FF),
    .SYNC_POL     (0)
  ) dut (
    .clk25          (clk25),
    .rst_n          (rst_n),
    .layer_rgb_flat (layer_rgb_flat),
    .layer_valid    (layer_valid),
    .layer_enable   (layer_enable),
    .flash_trigger  (flash_trigger),
    .video_on       (video_on),
    .hsync_in       (hsync_in),
    .vsync_in       (vsync_in),
`ifdef MIXER_BG_EN
    .bg_rgb         (bg_rgb),
`endif
    .vga_r          (vga_r),
    .vga_g          (vga_g),
    .vga_b          (vga_b),
    .hsync_out      (hsync_out),
    .vsync_out      (vsync_out),
    .flash_active   (flash_active)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: flash counters in frames, a one-pixel-deep memory of what the mixer must show next.
  int         cnt [L];
  logic [2:0] pend_rgb, show_rgb;
  logic       pend_hs, pend_vs, show_hs, show_vs;
  logic       v_last, v_last2;

  function automatic logic [OW-1:0] ex(input logic b);
    return b ? {OW{1'b1}} : {OW{1'b0}};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < L; i++) cnt[i] = 0;
    pend_rgb = 3'b000; show_rgb = 3'b000;
    pend_hs  = ~ACT;   pend_vs  = ~ACT;
    show_hs  = ~ACT;   show_vs  = ~ACT;
    v_last   = ~ACT;   v_last2  = ~ACT;
  endtask

  task automatic step();
    logic [2:0]   pix;
    logic         hit;
    logic         tick;
    logic [L-1:0] fa;
    @(posedge clk25);
    if (!rst_n) begin
      model_reset();
    end else begin
`ifdef MIXER_BG_EN
      pix = bg_rgb;
`else
      pix = 3'b000;
`endif
      hit = 1'b0;
      for (int i = 0; i < L; i++) begin
        if (!hit && layer_valid[i] && layer_enable[i]) begin
          if (cnt[i] == 0) begin
            hit = 1'b1; pix = layer_rgb_flat[3*i +: 3];
          end else if (cnt[i] % 2 == 1) begin
            hit = 1'b1; pix = 3'b111;
          end
        end
      end
      if (!video_on) pix = 3'b000;
      show_rgb = pend_rgb; show_hs = pend_hs; show_vs = pend_vs;
      pend_rgb = pix;      pend_hs = hsync_in; pend_vs = vsync_in;
      tick = (v_last == ACT) && (v_last2 != ACT);
      for (int i = 0; i < L; i++) begin
        if (flash_trigger[i]) cnt[i] = FF;
        else if (tick && cnt[i] > 0) cnt[i] = cnt[i] - 1;
      end
      v_last2 = v_last;
      v_last  = vsync_in;
    end
    @(negedge clk25);
    for (int i = 0; i < L; i++) fa[i] = (cnt[i] != 0);
    check_eq("vga_r", 32'(vga_r), 32'(ex(show_rgb[2])));
    check_eq("vga_g", 32'(vga_g), 32'(ex(show_rgb[1])));
    check_eq("vga_b", 32'(vga_b), 32'(ex(show_rgb[0])));
    check_eq("hsync_out", 32'(hsync_out), 32'(show_hs));
    check_eq("vsync_out", 32'(vsync_out), 32'(show_vs));
    check_eq("flash_active", 32'(flash_active), 32'(fa));
  endtask

  task automatic idle_inputs();
    layer_rgb_flat = '0; layer_valid = '0; layer_enable = '1;
    flash_trigger  = '0; video_on = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
`ifdef MIXER_BG_EN
    bg_rgb = 3'b000;
`endif
  endtask

  task automatic frame();
    vsync_in = 1'b1; step(); step(); step();
    vsync_in = 1'b0; step(); step();
    vsync_in = 1'b1;
  endtask

  task automatic count_frames_to_idle(input string tag);
    int n;
    n = 0;
    while (flash_active[1] && n < 20) begin
      frame();
      n++;
    end
    check_eq(tag, 32'(n), 32'(FF));
  endtask

  initial begin
    model_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    check_eq("rst_vga_r", 32'(vga_r), 32'h0);
    check_eq("rst_hsync", 32'(hsync_out), 32'h1);
    check_eq("rst_flash", 32'(flash_active), 32'h0);
    rst_n = 1'b1;

    // Layers 0 and 2 both valid: layer 0 (red) wins.
    layer_valid = 6'b000101;
    layer_rgb_flat[0 +: 3] = 3'b100;
    layer_rgb_flat[6 +: 3] = 3'b010;
    step(); step();
    check_eq("prio_r", 32'(vga_r), 32'hF);
    check_eq("prio_g", 32'(vga_g), 32'h0);
    layer_enable[0] = 1'b0;
    step(); step();
    check_eq("mask_g", 32'(vga_g), 32'hF);
    check_eq("mask_r", 32'(vga_r), 32'h0);
    video_on = 1'b0;
    step(); step();
    check_eq("blank_g", 32'(vga_g), 32'h0);

    // Layer 1 flash: blink for FF frames.
    idle_inputs();
    layer_valid = 6'b000010;
    layer_rgb_flat[3 +: 3] = 3'b001;
    flash_trigger[1] = 1'b1; step();
    flash_trigger[1] = 1'b0; step();
    count_frames_to_idle("flash_frames");

    // Retrigger coincident with a frame tick at count 3 reloads to FF.
    flash_trigger[1] = 1'b1; step();
    flash_trigger[1] = 1'b0; step();
    for (int k = 0; k < FF - 3; k++) frame();
    step();
    vsync_in = 1'b0; step();
    flash_trigger[1] = 1'b1; step();
    flash_trigger[1] = 1'b0; vsync_in = 1'b1; step();
    count_frames_to_idle("coincide_frames");

    // Asynchronous reset mid-line during a flash.
    flash_trigger[1] = 1'b1; hsync_in = 1'b0; step();
    flash_trigger[1] = 1'b0; step(); step();
    #5 rst_n = 1'b0;
    #1;
    check_eq("arst_vga_b", 32'(vga_b), 32'h0);
    check_eq("arst_hsync", 32'(hsync_out), 32'h1);
    check_eq("arst_vsync", 32'(vsync_out), 32'h1);
    check_eq("arst_flash", 32'(flash_active), 32'h0);
    step();
    rst_n = 1'b1;
    step(); step(); step();

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      layer_rgb_flat = 18'($urandom);
      layer_valid    = 6'($urandom);
      layer_enable   = 6'($urandom) | 6'($urandom);
      for (int i = 0; i < L; i++) flash_trigger[i] = ($urandom_range(0, 40) == 0);
      video_on = ($urandom_range(0, 7) != 0);
      hsync_in = 1'($urandom);
      if ($urandom_range(0, 5) == 0) vsync_in = ~vsync_in;
`ifdef MIXER_BG_EN
      bg_rgb = 3'($urandom);
`endif
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
